jescpu_core: RTL and testbench

- Parametrised multi-cycle accumulator CPU core. It fetches 3-word instructions (opcode, operand1, operand2) from a shared memory over a req/ready handshake and executes them.
- Drives NUM_OUT output registers that top level feeds to the LED scanner.
- Successor to the fixed 8-bit fetch1/fetch2/fetch3/compute/store skeleton: adds generic widths, a real ISA, flags, variable-latency memory, halt and output channels.

---
 rtl/jescpu_pkg.sv | 34 +++
 rtl/jescpu_alu.sv | 36 +++
 rtl/jescpu_core.sv | 226 ++++++++++++++++++++++
 tb/tb_jescpu_core.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jescpu_pkg.sv
// Shared opcodes, state encoding and decode helpers for the jescpu core.
// Optional single-step control is enabled with JESCPU_SINGLE_STEP_EN.
package jescpu_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LD   = 4'h1;
   localparam logic [3:0] OP_ST   = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_NAND = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_JC   = 4'h9;
   localparam logic [3:0] OP_OUT  = 4'hA;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH_OP,
      S_FETCH_A1,
      S_FETCH_A2,
      S_MEM_RD,
      S_EXEC,
      S_STORE,
      S_HALT
   } state_t;

   // Opcodes that read a memory operand into tmp before EXEC.
   function automatic logic needs_rd(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_NAND);
   endfunction

endpackage

// File: rtl/jescpu_alu.sv
// Combinational accumulator ALU for LD/ADD/SUB/NAND.
// Carry is only meaningful for ADD and SUB.
module jescpu_alu
   import jescpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] tmp,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] sum;

   // Result/carry selection per opcode.
   always_comb begin
      sum    = {1'b0, a} + {1'b0, tmp};
      result = a;
      carry  = 1'b0;
      unique case (op)
         OP_LD:   result = tmp;
         OP_ADD:  {carry, result} = sum;
         OP_SUB: begin
            result = a - tmp;
            carry  = (a >= tmp);
         end
         OP_NAND: result = ~(a & tmp);
         default: result = a;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/jescpu_core.sv
// Multi-cycle accumulator CPU: 3-word fetch over a req/ready bus.
// JESCPU_SINGLE_STEP_EN adds step/run inputs for instruction stepping.
module jescpu_core
   import jescpu_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int NUM_OUT  = 4,
   parameter int RESET_PC = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
`ifdef JESCPU_SINGLE_STEP_EN
   input  logic                      step,
   input  logic                      run,
`endif
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_ready,
   output logic [NUM_OUT*DATA_W-1:0] out_ports,
   output logic                      halted,
   output logic [ADDR_W-1:0]         pc_dbg
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic                z_q, z_d, c_q, c_d;
   logic [3:0]          op_q, op_d;
   logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d;
   logic [DATA_W-1:0]   tmp_q, tmp_d;
   logic [DATA_W-1:0]   outs_q [NUM_OUT];
   logic [DATA_W-1:0]   outs_d [NUM_OUT];
   logic                req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c, alu_z;
   logic                done;
   logic                go;

`ifdef JESCPU_SINGLE_STEP_EN
   logic step_q;

   // Edge register: a rising step edge releases one instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) step_q <= 1'b0;
      else        step_q <= step;
   end

   assign go = run | (step & ~step_q);
`else
   assign go = 1'b1;
`endif

   jescpu_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a_q),
      .tmp    (tmp_q),
      .op     (op_q),
      .result (alu_res),
      .carry  (alu_c),
      .zero   (alu_z)
   );

   assign done      = req_q & mem_ready;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign halted    = (state_q == S_HALT);
   assign pc_dbg    = pc_q;

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
      assign out_ports[k*DATA_W +: DATA_W] = outs_q[k];
   end

   // Architectural state and registered bus outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH_OP;
         pc_q    <= ADDR_W'(RESET_PC);
         a_q     <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         op_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         tmp_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         for (int k = 0; k < NUM_OUT; k++) outs_q[k] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         z_q     <= z_d;
         c_q     <= c_d;
         op_q    <= op_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         tmp_q   <= tmp_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         outs_q  <= outs_d;
      end
   end

   // Next-state, datapath and next-request logic.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      z_d     = z_q;
      c_d     = c_q;
      op_d    = op_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      tmp_d   = tmp_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      outs_d  = outs_q;
      case (state_q)
         S_FETCH_OP: begin
            if (!req_q) begin
               req_d  = go;
               we_d   = 1'b0;
               addr_d = pc_q;
            end else if (done) begin
               op_d    = mem_rdata[3:0];
               pc_d    = pc_q + ADDR_W'(1);
               addr_d  = pc_d;
               state_d = S_FETCH_A1;
            end
         end
         S_FETCH_A1: begin
            if (done) begin
               op1_d   = mem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               addr_d  = pc_d;
               state_d = S_FETCH_A2;
            end
         end
         S_FETCH_A2: begin
            if (done) begin
               op2_d = mem_rdata;
               pc_d  = pc_q + ADDR_W'(1);
               if (needs_rd(op_q)) begin
                  addr_d  = op1_q[ADDR_W-1:0];
                  state_d = S_MEM_RD;
               end else begin
                  req_d   = 1'b0;
                  state_d = S_EXEC;
               end
            end
         end
         S_MEM_RD: begin
            if (done) begin
               tmp_d   = mem_rdata;
               req_d   = 1'b0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_LD, OP_NAND: begin
                  a_d = alu_res;
                  z_d = alu_z;
               end
               OP_ADD, OP_SUB: begin
                  a_d = alu_res;
                  z_d = alu_z;
                  c_d = alu_c;
               end
               OP_LDI: begin
                  a_d = op1_q;
                  z_d = (op1_q == '0);
               end
               OP_JMP: pc_d = op1_q[ADDR_W-1:0];
               OP_JZ:  if (z_q) pc_d = op1_q[ADDR_W-1:0];
               OP_JC:  if (c_q) pc_d = op1_q[ADDR_W-1:0];
               OP_OUT: begin
                  for (int k = 0; k < NUM_OUT; k++)
                     if (op2_q == DATA_W'(k)) outs_d[k] = a_q;
               end
               default: ;
            endcase
            if (op_q == OP_ST) begin
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = op1_q[ADDR_W-1:0];
               wdata_d = a_q;
               state_d = S_STORE;
            end else if (op_q == OP_HLT) begin
               state_d = S_HALT;
            end else begin
               req_d   = go;
               we_d    = 1'b0;
               addr_d  = pc_d;
               state_d = S_FETCH_OP;
            end
         end
         S_STORE: begin
            if (done) begin
               req_d   = go;
               we_d    = 1'b0;
               addr_d  = pc_q;
               state_d = S_FETCH_OP;
            end
         end
         default: begin
            req_d = 1'b0;
            we_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_jescpu_core.sv
// Self-checking bench for jescpu_core with a latency-randomised memory
// and an access-trace scoreboard.
module tb_jescpu_core;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we;
   logic [7:0]  mem_addr, mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic [31:0] out_ports;
   logic        halted;
   logic [7:0]  pc_dbg;
`ifdef JESCPU_SINGLE_STEP_EN
   logic        step = 1'b0;
   logic        run = 1'b1;
`endif

   logic [7:0] mem [256];
   acc_t       acc_q[$];
   acc_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         lat_cnt = 0;
   int         lat_cur = 0;
   int         max_delay = 0;
   bit         stall = 1'b0;
   bit         pend = 1'b0;
   logic [7:0] s_addr, s_wdata;
   logic       s_we;
   int         stab_err = 0;

   always #5 clk = ~clk;

   jescpu_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef JESCPU_SINGLE_STEP_EN
      .step      (step),
      .run       (run),
`endif
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .out_ports (out_ports),
      .halted    (halted),
      .pc_dbg    (pc_dbg)
   );

   // Memory model: ready after lat_cur wait cycles; pending-request monitor.
   always @(negedge clk) begin
      if (pend && mem_req &&
          (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata))
         stab_err++;
      if (mem_req && !stall && lat_cnt >= lat_cur) begin
         mem_ready = 1'b1;
         mem_rdata = mem[mem_addr];
      end else begin
         mem_ready = 1'b0;
         if (mem_req) lat_cnt++;
      end
      pend    = mem_req && !mem_ready;
      s_addr  = mem_addr;
      s_we    = mem_we;
      s_wdata = mem_wdata;
   end

   // Completed accesses are logged as observed trace entries.
   always @(posedge clk) begin
      if (rst_n && mem_req && mem_ready) begin
         acc_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem[mem_addr]});
         if (mem_we) mem[mem_addr] = mem_wdata;
         lat_cnt = 0;
         lat_cur = $urandom_range(max_delay, 0);
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      exp_q.delete();
   endtask

   task automatic push_rd(input int a);
      exp_q.push_back({1'b0, 8'(a), mem[a]});
   endtask

   task automatic start(input int maxd);
      rst_n = 1'b0;
      max_delay = maxd;
      lat_cnt = 0;
      lat_cur = $urandom_range(maxd, 0);
      stab_err = 0;
      repeat (2) @(negedge clk);
      acc_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic run_to_halt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic load_add_prog();
      clear_mem();
      mem[0] = 8'h06; mem[1] = 8'h05; mem[2] = 8'h00;
      mem[3] = 8'h03; mem[4] = 8'h20; mem[5] = 8'h00;
      mem[6] = 8'h0A; mem[7] = 8'h00; mem[8] = 8'h02;
      mem[9] = 8'h0F; mem[10] = 8'h00; mem[11] = 8'h00;
      mem[8'h20] = 8'hFC;
      for (int i = 0; i < 6; i++) push_rd(i);
      push_rd(8'h20);
      for (int i = 6; i < 12; i++) push_rd(i);
   endtask

   task automatic test_reset();
      int n;
      clear_mem();
      mem[0] = 8'h06; mem[1] = 8'h77;
      mem[3] = 8'h0A; mem[5] = 8'h00;
      mem[6] = 8'h07; mem[7] = 8'h30;
      stall = 1'b0;
      start(0);
      n = 0;
      while (!(mem_req && mem_addr == 8'h30) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      stall = 1'b1;
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL reset_reach: req to 30 not seen after %0d cycles", n);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h30) begin
         failures++;
         $display("FAIL reset_hold: req=%b addr=%h, need 1/30", mem_req, mem_addr);
      end
      checks++;
      if (out_ports[7:0] !== 8'h77) begin
         failures++;
         $display("FAIL reset_pre_out: got %h need 77", out_ports[7:0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_we, halted} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ctrl: req/we/halt=%b need 000",
                  {mem_req, mem_we, halted});
      end
      checks++;
      if (out_ports !== 32'h0 || pc_dbg !== 8'h00) begin
         failures++;
         $display("FAIL reset_vals: out=%h pc=%h need 0/0", out_ports, pc_dbg);
      end
      checks++;
      if (dut.a_q !== 8'h00 || dut.z_q !== 1'b0 || dut.c_q !== 1'b0) begin
         failures++;
         $display("FAIL reset_acc: a=%h z=%b c=%b need 0", dut.a_q, dut.z_q, dut.c_q);
      end
      stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (!mem_req && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin
         failures++;
         $display("FAIL reset_first_req: req=%b we=%b addr=%h need 1/0/00",
                  mem_req, mem_we, mem_addr);
      end
   endtask

   task automatic test_add();
      int   cyc;
      acc_t e, o;
      load_add_prog();
      start(0);
      run_to_halt(cyc);
      checks++;
      if (cyc !== 18) begin
         failures++;
         $display("FAIL add_cycles: got %0d need 18", cyc);
      end
      checks++;
      if (out_ports[23:16] !== 8'h01 || halted !== 1'b1) begin
         failures++;
         $display("FAIL add_out: ch2=%h halted=%b need 01/1", out_ports[23:16], halted);
      end
      checks++;
      if (dut.c_q !== 1'b1 || dut.z_q !== 1'b0 || pc_dbg !== 8'd12) begin
         failures++;
         $display("FAIL add_flags: c=%b z=%b pc=%h need 1/0/0c",
                  dut.c_q, dut.z_q, pc_dbg);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b0 || acc_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL add_trace_len: req=%b got %0d need %0d",
                  mem_req, acc_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && acc_q.size() > 0) begin
         e = exp_q.pop_front();
         o = acc_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL add_trace: got %h need %h", o, e);
         end
      end
   endtask

   task automatic test_delayed();
      int cyc;
      for (int r = 0; r < 3; r++) begin
         load_add_prog();
         start(5);
         run_to_halt(cyc);
         checks++;
         if (out_ports !== 32'h0001_0000 || halted !== 1'b1 ||
             dut.c_q !== 1'b1 || dut.z_q !== 1'b0) begin
            failures++;
            $display("FAIL delay_final: out=%h halt=%b c=%b z=%b need 00010000/1/1/0",
                     out_ports, halted, dut.c_q, dut.z_q);
         end
         checks++;
         if (stab_err !== 0) begin
            failures++;
            $display("FAIL delay_stable: got %0d changes need 0", stab_err);
         end
         checks++;
         if (acc_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL delay_trace: got %0d need %0d", acc_q.size(), exp_q.size());
         end
      end
      max_delay = 0;
   endtask

   task automatic test_sub_jz(input logic [7:0] m, input logic [7:0] exp_pc,
                              input logic [7:0] exp_ch1, input logic exp_z,
                              input logic exp_c, input logic [7:0] exp_nxt);
      int cyc;
      clear_mem();
      mem[0] = 8'h06; mem[1] = 8'h03;
      mem[3] = 8'h04; mem[4] = 8'h20;
      mem[6] = 8'h08; mem[7] = 8'h40;
      mem[9] = 8'h0A; mem[11] = 8'h01;
      mem[12] = 8'h0F;
      mem[8'h40] = 8'h0A; mem[8'h43] = 8'h0F;
      mem[8'h20] = m;
      start(0);
      run_to_halt(cyc);
      checks++;
      if (dut.z_q !== exp_z || dut.c_q !== exp_c) begin
         failures++;
         $display("FAIL sub_flags m=%h: z=%b c=%b need %b/%b",
                  m, dut.z_q, dut.c_q, exp_z, exp_c);
      end
      checks++;
      if (out_ports[15:8] !== exp_ch1 || pc_dbg !== exp_pc) begin
         failures++;
         $display("FAIL sub_result m=%h: ch1=%h pc=%h need %h/%h",
                  m, out_ports[15:8], pc_dbg, exp_ch1, exp_pc);
      end
      checks++;
      if (acc_q.size() < 11 || acc_q[10].addr !== exp_nxt) begin
         failures++;
         $display("FAIL sub_next_fetch m=%h: got %h need %h", m,
                  (acc_q.size() < 11) ? 8'hxx : acc_q[10].addr, exp_nxt);
      end
   endtask

   task automatic test_st_wrap();
      int   cyc;
      acc_t e, o;
      clear_mem();
      mem[0] = 8'h06; mem[1] = 8'h5F; mem[2] = 8'h00;
      mem[3] = 8'h07; mem[4] = 8'hFE; mem[5] = 8'h00;
      mem[8'hFE] = 8'h02; mem[8'hFF] = 8'h10;
      for (int i = 0; i < 6; i++) push_rd(i);
      push_rd(8'hFE);
      push_rd(8'hFF);
      push_rd(0);
      exp_q.push_back({1'b1, 8'h10, 8'h5F});
      for (int i = 1; i < 4; i++) push_rd(i);
      start(2);
      run_to_halt(cyc);
      checks++;
      if (halted !== 1'b1 || pc_dbg !== 8'h04 || mem[8'h10] !== 8'h5F) begin
         failures++;
         $display("FAIL st_final: halt=%b pc=%h m10=%h need 1/04/5f",
                  halted, pc_dbg, mem[8'h10]);
      end
      checks++;
      if (acc_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL st_trace_len: got %0d need %0d", acc_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && acc_q.size() > 0) begin
         e = exp_q.pop_front();
         o = acc_q.pop_front();
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL st_trace: got %h need %h", o, e);
         end
      end
      max_delay = 0;
   endtask

`ifdef JESCPU_SINGLE_STEP_EN
   task automatic test_single_step();
      int reqs;
      run = 1'b0;
      step = 1'b0;
      load_add_prog();
      start(0);
      reqs = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (mem_req) reqs++;
      end
      checks++;
      if (reqs !== 0) begin
         failures++;
         $display("FAIL step_idle: got %0d req cycles need 0", reqs);
      end
      for (int s = 0; s < 2; s++) begin
         step = 1'b1;
         repeat (2) @(negedge clk);
         step = 1'b0;
         repeat (30) @(negedge clk);
         checks++;
         if (acc_q.size() !== (s == 0 ? 3 : 7) || mem_req !== 1'b0 ||
             pc_dbg !== (s == 0 ? 8'd3 : 8'd6)) begin
            failures++;
            $display("FAIL step_one s=%0d: acc=%0d req=%b pc=%h", s,
                     acc_q.size(), mem_req, pc_dbg);
         end
      end
      run = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_delayed();
      test_sub_jz(8'h03, 8'h46, 8'h00, 1'b1, 1'b1, 8'h40);
      test_sub_jz(8'h04, 8'h0F, 8'hFF, 1'b0, 1'b0, 8'h09);
      test_st_wrap();
`ifdef JESCPU_SINGLE_STEP_EN
      test_single_step();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
